backprop_hidden_error: RTL and testbench

Sequential back-propagation stage that consumes the output-layer deltas in sign/magnitude form (one `sign0` bit plus a 10-bit `delta0` magnitude per output neuron) and reconstructs a signed error for each hidden neuron. For each hidden neuron it computes the weighted sum of the output deltas through the hidden→output weights, using the same thousandths fixed-point scale. It sits downstream of the output-delta stage and feeds the hidden-layer delta/weight-update logic. Only one multiplier is used: it performs one multiply-accumulate (MAC) per clock.

---
 rtl/backprop_hidden_error_if.sv | 24 ++
 rtl/backprop_hidden_error.sv | 123 ++++++++++++
 tb/tb_backprop_hidden_error.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/backprop_hidden_error_if.sv
// Job bus for the hidden-layer error stage: start/delta/weight inputs and
// busy/done/error-sum outputs.
interface backprop_hidden_error_if #(
  parameter int unsigned N_OUT = 5,
  parameter int unsigned N_HID = 4
);
  logic               start;
  logic               sign0   [N_OUT];
  logic [9:0]         delta0  [N_OUT];
  logic signed [9:0]  w1      [N_HID][N_OUT];
  logic               busy;
  logic               done;
  logic signed [15:0] hid_err [N_HID];

  modport master (
    output start, sign0, delta0, w1,
    input  busy, done, hid_err
  );

  modport slave (
    input  start, sign0, delta0, w1,
    output busy, done, hid_err
  );
endinterface

// File: rtl/backprop_hidden_error.sv
// Hidden-layer error sums: one sign/magnitude MAC per clock over the latched
// output deltas and hidden->output weights (thousandths fixed point).
module backprop_hidden_error #(
  parameter int unsigned N_OUT = 5,
  parameter int unsigned N_HID = 4
) (
  input logic                    clk,
  input logic                    rst,
  backprop_hidden_error_if.slave bus
);
  localparam int unsigned IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned JW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam logic [IW-1:0] ILast = IW'(N_OUT - 1);
  localparam logic [JW-1:0] JLast = JW'(N_HID - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic               sign0_r  [N_OUT];
  logic [9:0]         delta0_r [N_OUT];
  logic signed [9:0]  w1_r     [N_HID][N_OUT];
  logic signed [15:0] res_q    [N_HID];
  logic signed [15:0] hid_err_q[N_HID];
  logic [IW-1:0]      i_q;
  logic [JW-1:0]      j_q;
  logic [15:0]        acc_q;
  logic               busy_q;
  logic               done_q;

  logic [9:0]  w_sel;
  logic [9:0]  w_abs;
  logic [19:0] mag;
  logic [19:0] quot;
  logic [15:0] term;
  logic        neg;
  logic [15:0] acc_d;
  logic        last_term;

  // Magnitude product then truncating divide, so rounding is toward zero
  // regardless of the term sign. |w| = 512 fits the 10-bit unsigned abs.
  always_comb begin
    w_sel = w1_r[j_q][i_q];
    w_abs = w_sel[9] ? (~w_sel + 10'd1) : w_sel;
    mag   = 20'(delta0_r[i_q]) * 20'(w_abs);
    quot  = mag / 20'd1000;
    term  = quot[15:0];
    neg   = sign0_r[i_q] ^ w_sel[9];
    acc_d = neg ? (acc_q - term) : (acc_q + term);
  end

  assign last_term = (i_q == ILast) && (j_q == JLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_term) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      i_q    <= '0;
      j_q    <= '0;
      acc_q  <= '0;
      for (int j = 0; j < N_HID; j++) begin
        res_q[j]     <= '0;
        hid_err_q[j] <= '0;
        for (int i = 0; i < N_OUT; i++) w1_r[j][i] <= '0;
      end
      for (int i = 0; i < N_OUT; i++) begin
        sign0_r[i]  <= 1'b0;
        delta0_r[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy also stays up across a back-to-back accept on the done cycle
          busy_q <= bus.start;
          if (bus.start) begin
            sign0_r  <= bus.sign0;
            delta0_r <= bus.delta0;
            w1_r     <= bus.w1;
            i_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
          end
        end
        StRun: begin
          if (i_q == ILast) begin
            res_q[j_q] <= acc_d;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= j_q + JW'(1);
          end else begin
            acc_q <= acc_d;
            i_q   <= i_q + IW'(1);
          end
        end
        StDone: begin
          done_q    <= 1'b1;
          hid_err_q <= res_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hid_err = hid_err_q;
endmodule

// File: tb/tb_backprop_hidden_error.sv
// Directed bench for backprop_hidden_error: hand-computed error sums, latency,
// start handling and reset behaviour at the default 5x4 geometry.
module tb_backprop_hidden_error;
  localparam int NO = 5;
  localparam int NH = 4;
  localparam int LAT = NO * NH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  backprop_hidden_error_if #(.N_OUT(NO), .N_HID(NH)) bus ();

  backprop_hidden_error #(.N_OUT(NO), .N_HID(NH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic clear_inputs();
    bus.start = 1'b0;
    for (int i = 0; i < NO; i++) begin
      bus.sign0[i]  = 1'b0;
      bus.delta0[i] = 10'd0;
      for (int j = 0; j < NH; j++) bus.w1[j][i] = 10'sd0;
    end
  endtask

  // Raise start before an edge E0 and drop it after; returns just after E0.
  task automatic start_job();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Cycles after E0 until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    for (int j = 0; j < NH; j++) begin
      n_cmp++;
      if (bus.hid_err[j] !== 16'sd0) begin
        n_err++;
        $display("FAIL reset_hid_err[%0d]: got %0d required 0", j, bus.hid_err[j]);
      end
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_start_ignored: busy=%b done=%b required 0 0", bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_single_positive();
    int lat;
    clear_inputs();
    bus.delta0[0] = 10'd1000;
    for (int j = 0; j < NH; j++) bus.w1[j][0] = 10'sd250;
    start_job();
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_after_accept: got %b required 1", bus.busy);
    end
    wait_done(lat);
    n_cmp++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL single_latency: got %0d required %0d", lat, LAT);
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy_with_done: got %b required 1", bus.busy);
    end
    for (int j = 0; j < NH; j++) begin
      n_cmp++;
      if (bus.hid_err[j] !== 16'sd250) begin
        n_err++;
        $display("FAIL single_hid_err[%0d]: got %0d required 250", j, bus.hid_err[j]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done_pulse: done=%b busy=%b required 0 0", bus.done, bus.busy);
    end
    n_cmp++;
    if (bus.hid_err[2] !== 16'sd250) begin
      n_err++;
      $display("FAIL single_hold: got %0d required 250", bus.hid_err[2]);
    end
  endtask

  task automatic test_mixed_signs();
    int lat;
    logic signed [15:0] exp_v [NH];
    clear_inputs();
    bus.delta0[0] = 10'd999;
    bus.delta0[1] = 10'd3;
    bus.sign0[0]  = 1'b1;
    bus.w1[0][0] = 10'sd1;    bus.w1[0][1] = -10'sd400;
    bus.w1[1][0] = -10'sd1;   bus.w1[1][1] = 10'sd400;
    bus.w1[2][0] = 10'sd500;
    exp_v[0] = -16'sd1;       // -(999/1000) + -(1200/1000)
    exp_v[1] = 16'sd1;        // +(999/1000) + (1200/1000)
    exp_v[2] = -16'sd499;     // -(499500/1000)
    exp_v[3] = 16'sd0;
    start_job();
    wait_done(lat);
    for (int j = 0; j < NH; j++) begin
      n_cmp++;
      if (bus.hid_err[j] !== exp_v[j]) begin
        n_err++;
        $display("FAIL mixed_hid_err[%0d]: got %0d required %0d", j, bus.hid_err[j], exp_v[j]);
      end
    end
  endtask

  task automatic test_extremes();
    int lat;
    for (int pass = 0; pass < 2; pass++) begin
      clear_inputs();
      for (int i = 0; i < NO; i++) begin
        bus.delta0[i] = 10'd1023;
        bus.sign0[i]  = (pass == 0);
        for (int j = 0; j < NH; j++) bus.w1[j][i] = -10'sd512;
      end
      start_job();
      wait_done(lat);
      for (int j = 0; j < NH; j++) begin
        n_cmp++;
        if (bus.hid_err[j] !== ((pass == 0) ? 16'sd2615 : -16'sd2615)) begin
          n_err++;
          $display("FAIL extreme_hid_err[%0d] pass %0d: got %0d required %0d", j, pass,
                   bus.hid_err[j], (pass == 0) ? 2615 : -2615);
        end
      end
    end
  endtask

  task automatic test_latch_and_ignored_start();
    int n_done = 0;
    clear_inputs();
    bus.delta0[0] = 10'd1000;
    for (int j = 0; j < NH; j++) bus.w1[j][0] = 10'(100 * (j + 1));
    start_job();
    for (int i = 0; i < NO; i++) begin
      bus.delta0[i] = 10'd1023;
      for (int j = 0; j < NH; j++) bus.w1[j][i] = 10'sd7;
    end
    for (int c = 1; c <= 60; c++) begin
      bus.start = (c == 5);
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    bus.start = 1'b0;
    n_cmp++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL latch_done_count: got %0d required 1", n_done);
    end
    for (int j = 0; j < NH; j++) begin
      n_cmp++;
      if (bus.hid_err[j] !== 16'(100 * (j + 1))) begin
        n_err++;
        $display("FAIL latch_hid_err[%0d]: got %0d required %0d", j, bus.hid_err[j],
                 100 * (j + 1));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int n_done = 0;
    start_job();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_ctrl: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    for (int j = 0; j < NH; j++) begin
      n_cmp++;
      if (bus.hid_err[j] !== 16'sd0) begin
        n_err++;
        $display("FAIL midrst_hid_err[%0d]: got %0d required 0", j, bus.hid_err[j]);
      end
    end
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    n_cmp++;
    if (n_done != 0) begin
      n_err++;
      $display("FAIL midrst_no_done: got %0d pulses required 0", n_done);
    end
    clear_inputs();
    bus.delta0[0] = 10'd1000;
    for (int j = 0; j < NH; j++) bus.w1[j][0] = 10'sd250;
    start_job();
    wait_done(lat);
    n_cmp++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL midrst_restart_latency: got %0d required %0d", lat, LAT);
    end
    n_cmp++;
    if (bus.hid_err[3] !== 16'sd250) begin
      n_err++;
      $display("FAIL midrst_restart_hid_err: got %0d required 250", bus.hid_err[3]);
    end
  endtask

  task automatic test_back_to_back();
    int c = 0;
    int first = -1;
    int second = -1;
    clear_inputs();
    bus.delta0[1] = 10'd500;
    bus.sign0[1]  = 1'b1;
    for (int j = 0; j < NH; j++) bus.w1[j][1] = 10'sd200;
    @(negedge clk);
    bus.start = 1'b1;
    while (second < 0 && c < 100) begin
      @(negedge clk);
      c++;
      if (bus.done === 1'b1) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (second - first != LAT + 1) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d required %0d", second - first, LAT + 1);
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_busy_with_done: got %b required 1", bus.busy);
    end
    n_cmp++;
    if (bus.hid_err[0] !== -16'sd100) begin
      n_err++;
      $display("FAIL b2b_hid_err: got %0d required -100", bus.hid_err[0]);
    end
    repeat (LAT + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_positive();
    test_mixed_signs();
    test_extremes();
    test_latch_and_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
